seg_display_scan: RTL

Four-digit multiplexed 7-segment driver sitting directly downstream of the real-time clock counter. Consumes its four BCD digits (hour tens, hour ones, minute tens, minute ones) and time-multiplexes them onto a common-anode display, one digit per scan slot. A blinking colon is driven on the decimal point of the hour-ones digit. Digits are snapshotted once per frame so a counter update never tears a displayed value.

---
 rtl/seg_display_scan_if.sv | 24 ++
 rtl/seg_display_scan.sv | 112 +++++++++++
 2 files changed

// File: rtl/seg_display_scan_if.sv
// Digit inputs from the RTC counter and the multiplexed display outputs.
// Latency: n/a (wires only).
// Backpressure: none; the display is a pure sink and the digits are level inputs.
interface seg_display_scan_if;
   logic [3:0] hr1_i;
   logic [3:0] hr2_i;
   logic [3:0] min1_i;
   logic [3:0] min2_i;
   logic [6:0] seg_o;
   logic [3:0] an_o;
   logic       dp_o;

   // Master side: the clock counter driving digits and observing the display.
   modport master (
      output hr1_i, hr2_i, min1_i, min2_i,
      input  seg_o, an_o, dp_o
   );

   // Slave side: the scan driver.
   modport slave (
      input  hr1_i, hr2_i, min1_i, min2_i,
      output seg_o, an_o, dp_o
   );
endinterface

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed common-anode 7-segment driver with blinking colon on hr2 dp.
// Latency: 1 cycle from scan/colon/shadow state to seg_o/an_o/dp_o.
// Backpressure: none; counters free-run and inputs are sampled once per frame.
module seg_display_scan #(
   parameter int SCAN_DIV   = 50000,
   parameter int GUARD      = 4,
   parameter int COLON_DIV  = 25000000,
   parameter int BLANK_LEAD = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   seg_display_scan_if.slave  bus
);

   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int CCNT_W = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  GUARD_V   = CNT_W'(GUARD);
   localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(COLON_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [1:0]        slot_q,  slot_d;
   logic [CCNT_W-1:0] ccnt_q,  ccnt_d;
   logic              colon_q, colon_d;
   // Shadow digits indexed by slot: [3]=hr1, [2]=hr2, [1]=min1, [0]=min2.
   logic [3:0][3:0]   sh_q,    sh_d;
   logic [6:0]        seg_q,   seg_d;
   logic [3:0]        an_q,    an_d;
   logic              dp_q,    dp_d;

   logic              snap;
   logic              guard;
   logic [3:0]        digit;

   // Active-low {g,f,e,d,c,b,a} decode; non-BCD values blank the digit.
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = SEG_BLANK;
      endcase
   endfunction

   // Next-state for scan/colon counters, frame snapshot and registered outputs.
   always_comb begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      slot_d  = (cnt_q == CNT_LAST) ? slot_q - 2'd1 : slot_q;
      ccnt_d  = (ccnt_q == CCNT_LAST) ? '0 : ccnt_q + 1'b1;
      colon_d = (ccnt_q == CCNT_LAST) ? ~colon_q : colon_q;

      // Snapshot at the first cycle of a frame; decode from the new shadow so
      // the captured value reaches the display on that same edge.
      snap = (cnt_q == '0) && (slot_q == 2'd3);
      sh_d = snap ? {bus.hr1_i, bus.hr2_i, bus.min1_i, bus.min2_i} : sh_q;

      guard = (cnt_q < GUARD_V);
      digit = sh_d[slot_q];

      seg_d = decode(digit);
      if ((BLANK_LEAD != 0) && (slot_q == 2'd3) && (digit == 4'd0)) begin
         seg_d = SEG_BLANK;
      end
      an_d = ~(4'b0001 << slot_q);
      dp_d = ~(colon_q && (slot_q == 2'd2));

      // Dark interval at slot start so the previous digit cannot ghost.
      if (guard) begin
         seg_d = SEG_BLANK;
         an_d  = 4'hF;
         dp_d  = 1'b1;
      end
   end

   // State and output registers; reset forces a dark display at slot 3.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         slot_q  <= 2'd3;
         ccnt_q  <= '0;
         colon_q <= 1'b0;
         sh_q    <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= 4'hF;
         dp_q    <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         ccnt_q  <= ccnt_d;
         colon_q <= colon_d;
         sh_q    <= sh_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.seg_o = seg_q;
   assign bus.an_o  = an_q;
   assign bus.dp_o  = dp_q;

endmodule
